peak_result_packer: RTL and testbench

- Downstream stage of the per-range-bin peak detector in the lidar spectral chain.
- Captures one {peak value, peak address} result per range bin on the rising edge of the detector's output-valid window.
- Tags each result with its range-bin index and buffers it in a small FIFO.
- Streams 64-bit result words to the host-transfer interface over a valid/ready handshake, marks the last bin of each frame, and counts dropped results.

---
 rtl/peak_result_packer_if.sv | 21 ++
 rtl/peak_result_packer.sv | 108 ++++++++++
 tb/tb_peak_result_packer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_result_packer_if.sv
// Result-word stream from the peak packer to the host-transfer stage.
interface peak_result_packer_if;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/peak_result_packer.sv
// Captures one peak result per range bin, tags it with its bin index,
// buffers it and streams 64-bit words with a frame-last marker.
module peak_result_packer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic [4:0]                 rangebin_num,
    input  logic                       peak_valid_in,
    input  logic [31:0]                peak_value_in,
    input  logic [9:0]                 peak_addr_in,
    peak_result_packer_if.master       dst,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        last;
        logic [4:0]  bin;
        logic [9:0]  addr;
        logic [31:0] val;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           rd_entry;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             valid_d;
    logic [4:0]       bin_idx;
    logic [4:0]       bin_base;
    logic [CNT_W-1:0] drop_base;
    logic             rd_fire;
    logic             full;
    logic             cap;
    logic             in_range;
    logic             wr_en;
    logic             drop;
    logic             nonempty_next;

    always_comb begin
        rd_fire   = dst.out_valid && dst.out_ready;
        rd_next   = rd_ptr + {{AW{1'b0}}, rd_fire};
        full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        cap       = peak_valid_in && !valid_d;
        bin_base  = frame_start ? 5'd0 : bin_idx;
        drop_base = frame_start ? '0 : drop_cnt;
        in_range  = (rangebin_num != 5'd0) && (bin_base < rangebin_num);
        // A full FIFO still takes the write when a word leaves this cycle
        wr_en     = cap && in_range && (!full || rd_fire);
        drop      = cap && !wr_en;
        wr_entry.last = (bin_base == rangebin_num - 5'd1);
        wr_entry.bin  = bin_base;
        wr_entry.addr = peak_addr_in;
        wr_entry.val  = peak_value_in;
        // Empty test uses the pre-write pointer: one cycle of write latency
        nonempty_next = (wr_ptr != rd_next);
        rd_entry      = mem[rd_next[AW-1:0]];
    end

    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d       <= 1'b0;
            bin_idx       <= 5'd0;
            drop_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            dst.out_valid <= 1'b0;
            dst.out_last  <= 1'b0;
            dst.out_data  <= '0;
            frame_done    <= 1'b0;
        end else begin
            valid_d    <= peak_valid_in;
            // Only full-FIFO rejects consume a bin; excess bins do not
            bin_idx    <= (cap && in_range) ? bin_base + 5'd1 : bin_base;
            if (drop && !(&drop_base)) begin
                drop_cnt <= drop_base + 1'b1;
            end else begin
                drop_cnt <= drop_base;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr        <= rd_next;
            dst.out_valid <= nonempty_next;
            if (nonempty_next) begin
                dst.out_last <= rd_entry.last;
                dst.out_data <= {rd_entry.bin, 17'd0,
                                 rd_entry.addr, rd_entry.val};
            end
            frame_done <= rd_fire && dst.out_last;
        end
    end
endmodule

// File: tb/tb_peak_result_packer.sv
// Directed-vector bench for peak_result_packer with a queue-based
// scoreboard checked by an independent output monitor.
module tb_peak_result_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [4:0]  rangebin_num;
    logic        peak_valid_in;
    logic [31:0] peak_value_in;
    logic [9:0]  peak_addr_in;
    logic        frame_done;
    logic [7:0]  drop_cnt;
    logic [4:0]  fifo_level;

    peak_result_packer_if bus ();

    peak_result_packer #(.DEPTH(16), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .rangebin_num  (rangebin_num),
        .peak_valid_in (peak_valid_in),
        .peak_value_in (peak_value_in),
        .peak_addr_in  (peak_addr_in),
        .dst           (bus.master),
        .frame_done    (frame_done),
        .drop_cnt      (drop_cnt),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [64:0] exp_q [$];

    task automatic chk(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int bin, input logic [9:0] a,
                        input logic [31:0] v, input logic last);
        logic [4:0] b;
        b = 5'(bin);
        exp_q.push_back({last, b, 17'd0, a, v});
    endtask

    task automatic win(input logic [31:0] v, input logic [9:0] a,
                       input int len);
        peak_value_in = v;
        peak_addr_in  = a;
        peak_valid_in = 1'b1;
        repeat (len) tick();
        peak_valid_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk(name, 65'(exp_q.size()), 65'd0);
    endtask

    // Output monitor: scoreboard pops, stall stability, frame_done timing
    logic        pend_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_word = '0;
    logic [64:0] got;

    always @(negedge clk) begin
        if (rst) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            got = {bus.out_last, bus.out_data};
            if (pend_done || frame_done)
                chk("frame_done", 65'(frame_done), 65'(pend_done));
            if (prev_stall) begin
                chk("stall_valid", 65'(bus.out_valid), 65'd1);
                chk("stall_data", got, prev_word);
            end
            pend_done = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none",
                             got);
                end else begin
                    chk("word", got, exp_q.pop_front());
                end
                pend_done = bus.out_last;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = got;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        frame_start   = 1'b0;
        rangebin_num  = 5'd3;
        peak_valid_in = 1'b0;
        peak_value_in = '0;
        peak_addr_in  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 65'(bus.out_valid), 65'd0);
        chk("rst_last", 65'(bus.out_last), 65'd0);
        chk("rst_done", 65'(frame_done), 65'd0);
        chk("rst_data", 65'(bus.out_data), 65'd0);
        chk("rst_drop", 65'(drop_cnt), 65'd0);
        chk("rst_level", 65'(fifo_level), 65'd0);
        rst = 1'b0;
        tick();

        // Basic frame with latency check on the first word
        fstart();
        push(0, 10'd5, 32'h100, 1'b0);
        push(1, 10'd6, 32'h200, 1'b0);
        push(2, 10'd7, 32'h300, 1'b1);
        peak_value_in = 32'h100;
        peak_addr_in  = 10'd5;
        peak_valid_in = 1'b1;
        tick();
        chk("lat_n1", 65'(bus.out_valid), 65'd0);
        tick();
        chk("lat_n2", 65'(bus.out_valid), 65'd1);
        peak_valid_in = 1'b0;
        repeat (2) tick();
        win(32'h200, 10'd6, 1);
        win(32'h300, 10'd7, 3);
        drain("basic_drain");
        chk("basic_drop", 65'(drop_cnt), 65'd0);

        // Long window yields a single entry
        fstart();
        bus.out_ready = 1'b0;
        chk("long_lvl0", 65'(fifo_level), 65'd0);
        peak_value_in = 32'hCAFE;
        peak_addr_in  = 10'd99;
        peak_valid_in = 1'b1;
        tick();
        tick();
        chk("long_lvl1", 65'(fifo_level), 65'd1);
        repeat (22) tick();
        chk("long_lvl_end", 65'(fifo_level), 65'd1);
        peak_valid_in = 1'b0;
        tick();
        push(0, 10'd99, 32'hCAFE, 1'b0);
        bus.out_ready = 1'b1;
        drain("long_drain");

        // Backpressure until full, then write-while-full with a read
        rangebin_num = 5'd31;
        fstart();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) push(i, 10'(i + 100), 32'(32'h1000 + i), 1'b0);
            win(32'(32'h1000 + i), 10'(i + 100), 1);
        end
        chk("bp_level", 65'(fifo_level), 65'd16);
        chk("bp_drop", 65'(drop_cnt), 65'd2);
        push(18, 10'd300, 32'hBEEF, 1'b0);
        peak_value_in = 32'hBEEF;
        peak_addr_in  = 10'd300;
        peak_valid_in = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        peak_valid_in = 1'b0;
        bus.out_ready = 1'b0;
        chk("wfull_level", 65'(fifo_level), 65'd16);
        chk("wfull_drop", 65'(drop_cnt), 65'd2);
        repeat (3) tick();
        bus.out_ready = 1'b1;
        drain("bp_drain");

        // Excess bins are dropped without advancing the bin index
        rangebin_num = 5'd2;
        fstart();
        push(0, 10'd1, 32'hA0, 1'b0);
        push(1, 10'd2, 32'hA1, 1'b1);
        win(32'hA0, 10'd1, 1);
        win(32'hA1, 10'd2, 1);
        win(32'hA2, 10'd3, 1);
        win(32'hA3, 10'd4, 1);
        chk("excess_drop", 65'(drop_cnt), 65'd2);
        drain("excess_drain");
        fstart();
        chk("fs_drop_clr", 65'(drop_cnt), 65'd0);
        push(0, 10'd8, 32'hB0, 1'b0);
        win(32'hB0, 10'd8, 1);
        drain("fs_drain");

        // frame_start coinciding with a capture edge
        push(0, 10'd9, 32'hC0, 1'b0);
        push(1, 10'd10, 32'hC1, 1'b1);
        peak_value_in = 32'hC0;
        peak_addr_in  = 10'd9;
        peak_valid_in = 1'b1;
        frame_start   = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        peak_valid_in = 1'b0;
        tick();
        win(32'hC1, 10'd10, 1);
        drain("coin_drain");

        // Capture disabled: every result dropped
        rangebin_num  = 5'd0;
        peak_valid_in = 1'b1;
        frame_start   = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("dis_drop1", 65'(drop_cnt), 65'd1);
        peak_valid_in = 1'b0;
        tick();
        win(32'hD0, 10'd11, 1);
        chk("dis_drop2", 65'(drop_cnt), 65'd2);
        chk("dis_level", 65'(fifo_level), 65'd0);

        // Reset with words buffered
        rangebin_num = 5'd31;
        fstart();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(i, 10'(i), 32'(32'hE0 + i), 1'b0);
            win(32'(32'hE0 + i), 10'(i), 1);
        end
        chk("pre_rst_valid", 65'(bus.out_valid), 65'd1);
        chk("pre_rst_level", 65'(fifo_level), 65'd5);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_valid", 65'(bus.out_valid), 65'd0);
        chk("mid_rst_level", 65'(fifo_level), 65'd0);
        chk("mid_rst_drop", 65'(drop_cnt), 65'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        push(0, 10'd77, 32'hF0, 1'b0);
        win(32'hF0, 10'd77, 1);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
